program_loader: RTL and testbench

Boot-time loader sitting directly upstream of the single-cycle core's program memory. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into program memory through a dedicated write port and holds the core in reset until the image is complete. It then releases the core, which fetches from byte address 0.

---
 rtl/program_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_program_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time byte-stream loader for the core's program memory
//
// Purpose:
//   Receives a byte stream over a valid/ready handshake and assembles
//   little-endian 32-bit words from it. Each word goes into program memory
//   through a dedicated write port. The core is held in reset until the
//   whole image has been accepted.
//   Stream layout: N[7:0], N[15:8], then 4*N payload bytes (LSB first per
//   word), then one XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// Configuration:
//   LOADER_CHECKSUM_EN - when defined, enables the running XOR over the
//   payload and the CHECK state that compares it against a trailing byte.
//
// Ports:
//   clk          in   core clock, rising edge
//   reset        in   synchronous active-low reset
//   start_i      in   begin/restart a load (IDLE, DONE, ERROR only)
//   rx_valid_i   in   rx_data_i holds a byte
//   rx_data_i    in   stream byte
//   rx_ready_o   out  loader accepts a byte this cycle
//   mem_we_o     out  program-memory write strobe, one cycle per word
//   mem_addr_o   out  word-aligned byte address of the write
//   mem_wdata_o  out  assembled instruction word
//   core_reset_o out  active-low core reset, high only in DONE
//   busy_o       out  load in progress
//   done_o       out  image loaded and accepted
//   error_o      out  load rejected

module program_loader #(
   parameter int PROGRAM_MEMORY_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        core_reset_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR_LO  = 3'd1;
   localparam logic [2:0] ST_HDR_HI  = 3'd2;
   localparam logic [2:0] ST_PAYLOAD = 3'd3;
   localparam logic [2:0] ST_WRITE   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_CHECK   = 3'd5;
`endif
   localparam logic [2:0] ST_DONE    = 3'd6;
   localparam logic [2:0] ST_ERROR   = 3'd7;

   localparam logic [15:0] MAX_WORDS = 16'(PROGRAM_MEMORY_DEPTH);

   logic [2:0]  state_q,    state_d;
   logic [7:0]  n_lo_q,     n_lo_d;
   logic [15:0] n_q,        n_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] word_q,     word_d;      // lanes 0..2; lane 3 arrives with the write
   logic [31:0] addr_q,     addr_d;
   logic [31:0] wdata_q,    wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  chk_q,      chk_d;
`endif

   logic        xfer;
   logic [15:0] n_hdr;
   logic [15:0] word_idx_inc;
   logic [2:0]  state_after_image;

   // Handshake and status are pure decodes of the registered state, so
   // nothing here depends combinationally on rx_valid_i.
   always_comb begin
      rx_ready_o = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                   (state_q == ST_PAYLOAD);
`ifdef LOADER_CHECKSUM_EN
      rx_ready_o = rx_ready_o || (state_q == ST_CHECK);
`endif
   end

   assign mem_we_o     = (state_q == ST_WRITE);
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign done_o       = (state_q == ST_DONE);
   assign core_reset_o = (state_q == ST_DONE);
   assign error_o      = (state_q == ST_ERROR);
   assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                         (state_q != ST_ERROR);

   assign xfer         = rx_valid_i && rx_ready_o;
   assign n_hdr        = {rx_data_i, n_lo_q};
   assign word_idx_inc = word_idx_q + 16'd1;

   // Where the load goes once the last word (or an empty header) is through.
`ifdef LOADER_CHECKSUM_EN
   assign state_after_image = ST_CHECK;
`else
   assign state_after_image = ST_DONE;
`endif

   always_comb begin
      state_d    = state_q;
      n_lo_d     = n_lo_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d      = chk_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               state_d    = ST_HDR_LO;
               word_idx_d = 16'd0;
               byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = 8'd0;
`endif
            end
         end

         ST_HDR_LO: begin
            if (xfer) begin
               n_lo_d  = rx_data_i;
               state_d = ST_HDR_HI;
            end
         end

         ST_HDR_HI: begin
            if (xfer) begin
               n_d = n_hdr;
               if (n_hdr > MAX_WORDS) begin
                  state_d = ST_ERROR;
               end else if (n_hdr == 16'd0) begin
                  state_d = state_after_image;
               end else begin
                  state_d    = ST_PAYLOAD;
                  word_idx_d = 16'd0;
                  byte_idx_d = 2'd0;
               end
            end
         end

         ST_PAYLOAD: begin
            if (xfer) begin
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ rx_data_i;
`endif
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = rx_data_i;
                  2'd1: word_d[15:8]  = rx_data_i;
                  2'd2: word_d[23:16] = rx_data_i;
                  default: begin
                     // Word complete: present it on the write port so it is
                     // valid for exactly the WRITE cycle and held afterwards.
                     wdata_d = {rx_data_i, word_q};
                     addr_d  = {14'd0, word_idx_q, 2'b00};
                     state_d = ST_WRITE;
                  end
               endcase
            end
         end

         ST_WRITE: begin
            word_idx_d = word_idx_inc;
            if (word_idx_inc == n_q) begin
               state_d = state_after_image;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end

`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (xfer) begin
               state_d = (rx_data_i == chk_q) ? ST_DONE : ST_ERROR;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         n_lo_q     <= 8'd0;
         n_q        <= 16'd0;
         word_idx_q <= 16'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 24'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         n_lo_q     <= n_lo_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader

module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        core_reset_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   program_loader #(.PROGRAM_MEMORY_DEPTH(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .rx_valid_i   (rx_valid_i),
      .rx_data_i    (rx_data_i),
      .rx_ready_o   (rx_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .core_reset_o (core_reset_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
   localparam int CHK_EXTRA = 1;
   logic [7:0] chk_flip;
`else
   localparam int CHK_EXTRA = 0;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          t_start = 0;
   int          write_cnt = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] img[4];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Every write strobe pops the next expected (address, word) pair.
   always @(negedge clk) begin
      if (mem_we_o) begin
         write_cnt++;
         check("ready_in_write", 32'(rx_ready_o), 32'd0);
         if (exp_addr_q.size() == 0) begin
            check("write_not_expected", 32'(mem_we_o), 32'd0);
         end else begin
            check("wr_addr", mem_addr_o, exp_addr_q.pop_front());
            check("wr_data", mem_wdata_o, exp_data_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(negedge clk);
      while (!rx_ready_o && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check("ready_timeout", 32'(rx_ready_o), 32'd1);
      @(posedge clk);
      #1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'hxx;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_load();
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      t_start = cyc;
   endtask

   // Sends header, payload from img[] and (when enabled) the checksum;
   // the expected writes are queued as the stimulus is produced.
   task automatic run_load(input int n, input bit gap);
      logic [7:0] x = 8'h00;
      logic [31:0] w;
      send_byte(8'(n), gap);
      send_byte(8'(n >> 8), gap);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         exp_addr_q.push_back(32'(i * 4));
         exp_data_q.push_back(w);
         for (int k = 0; k < 4; k++) begin
            x = x ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], gap);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ chk_flip, gap);
`else
      if (x == 8'h00) begin end
`endif
   endtask

   task automatic wait_end(output int lat);
      int waited = 0;
      @(negedge clk);
      while (!done_o && !error_o && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) check("end_timeout", 32'(done_o | error_o), 32'd1);
      lat = cyc - t_start;
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_rx_ready"},   32'(rx_ready_o),   32'd0);
      check({pfx, "_mem_we"},     32'(mem_we_o),     32'd0);
      check({pfx, "_mem_addr"},   mem_addr_o,        32'd0);
      check({pfx, "_mem_wdata"},  mem_wdata_o,       32'd0);
      check({pfx, "_core_reset"}, 32'(core_reset_o), 32'd0);
      check({pfx, "_busy"},       32'(busy_o),       32'd0);
      check({pfx, "_done"},       32'(done_o),       32'd0);
      check({pfx, "_error"},      32'(error_o),      32'd0);
   endtask

   initial begin
      int lat;
      reset      = 1'b0;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
`ifdef LOADER_CHECKSUM_EN
      chk_flip   = 8'h00;
`endif
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle_outputs("rst");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // single word, back-to-back bytes, latency from start to done
      img[0] = 32'h00A00513;
      write_cnt = 0;
      start_load();
      check("busy_after_start", 32'(busy_o), 32'd1);
      run_load(1, 1'b0);
      wait_end(lat);
      check("t1_done", 32'(done_o), 32'd1);
      check("t1_core_reset", 32'(core_reset_o), 32'd1);
      check("t1_busy", 32'(busy_o), 32'd0);
      check("t1_latency", 32'(lat), 32'(7 + CHK_EXTRA));
      check("t1_writes", 32'(write_cnt), 32'd1);

      // three words with rx_valid_i toggling
      img[0] = 32'h11223344;
      img[1] = 32'hDEADBEEF;
      img[2] = 32'h0F1E2D3C;
      write_cnt = 0;
      @(posedge clk);
      #1;
      start_load();
      check("restart_core_held", 32'(core_reset_o), 32'd0);
      run_load(3, 1'b1);
      wait_end(lat);
      check("t2_done", 32'(done_o), 32'd1);
      check("t2_writes", 32'(write_cnt), 32'd3);
      check("t2_sb_empty", 32'(exp_addr_q.size()), 32'd0);

      // oversized header
      write_cnt = 0;
      start_load();
      send_byte(8'h41, 1'b0);
      send_byte(8'h00, 1'b0);
      @(negedge clk);
      check("t3_error", 32'(error_o), 32'd1);
      check("t3_done", 32'(done_o), 32'd0);
      check("t3_core_reset", 32'(core_reset_o), 32'd0);
      repeat (3) @(negedge clk);
      check("t3_writes", 32'(write_cnt), 32'd0);
      check("t3_error_held", 32'(error_o), 32'd1);
      @(posedge clk);
      #1;

      // empty image
      write_cnt = 0;
      start_load();
      run_load(0, 1'b0);
      wait_end(lat);
      check("t4_done", 32'(done_o), 32'd1);
      check("t4_writes", 32'(write_cnt), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      @(posedge clk);
      #1;
      chk_flip = 8'h01;
      start_load();
      run_load(0, 1'b0);
      wait_end(lat);
      check("t4_bad_chk_error", 32'(error_o), 32'd1);

      // one word, wrong checksum: rejected but still written
      img[0] = 32'h00A00513;
      write_cnt = 0;
      @(posedge clk);
      #1;
      start_load();
      run_load(1, 1'b0);
      wait_end(lat);
      check("t5_error", 32'(error_o), 32'd1);
      check("t5_core_reset", 32'(core_reset_o), 32'd0);
      check("t5_writes", 32'(write_cnt), 32'd1);
      chk_flip = 8'h00;
`endif

      // reset in the middle of the second word
      img[0] = 32'hCAFEF00D;
      img[1] = 32'h12345678;
      write_cnt = 0;
      @(posedge clk);
      #1;
      start_load();
      exp_addr_q.push_back(32'd0);
      exp_data_q.push_back(img[0]);
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b0);
      for (int k = 0; k < 2; k++) send_byte(img[1][8*k +: 8], 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_idle_outputs("midrst");
      check("t6_partial_writes", 32'(write_cnt), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      write_cnt = 0;
      start_load();
      run_load(2, 1'b0);
      wait_end(lat);
      check("t6_done", 32'(done_o), 32'd1);
      check("t6_writes", 32'(write_cnt), 32'd2);
      check("t6_sb_empty", 32'(exp_addr_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
